fwd_hazard_scoreboard: RTL and testbench
========================================

// Module: fwd_hazard_scoreboard
// PURPOSE
//   Next-generation forwarding/hazard unit for the int+float RISC-V pipeline. Produces per-operand
//   forward selects for NUM_SRC EX-stage sources. Adds ID-stage stall generation for load-use hazards
//   and a multi-cycle-op scoreboard (FP div/sqrt/FMA) with per-register latency countdown.
//   Sits between the ID/EX pipeline registers and the EX operand muxes. Drives PC/IF-ID hold.
// PARAMETERS
//   AW       5  register address width (2**AW regs per bank)
//   NUM_SRC  3  source operands per instruction (rs1, rs2, rs3 for FMA)
//   MAX_LAT  8  max multi-cycle latency; counter width LW = $clog2(MAX_LAT+1)
// PORTS
//   clk             in   1           pipeline clock
//   rst_n           in   1           async active-low reset
//   id_valid        in   1           valid instruction in ID
//   id_rs_addr      in   NUM_SRC*AW  ID source addresses; id_rs_bank/id_rs_used in NUM_SRC each (bank 1=float)
//   id_rd, id_rd_bank, id_rd_wr  in  AW,1,1  ID destination
//   id_ex_rd, id_ex_rd_bank, id_ex_regwrite, id_ex_is_load  in AW,1,1,1  instruction now in EX
//   ex_rs_addr      in   NUM_SRC*AW  EX source addresses; ex_rs_bank in NUM_SRC
//   ex_mem_rd, ex_mem_rd_bank, ex_mem_regwrite  in AW,1,1
//   mem_wb_rd, mem_wb_rd_bank, mem_wb_regwrite  in AW,1,1
//   issue_lat       in   LW          latency of ID instruction; 0 = single-cycle op
//   fwd_sel         out  2*NUM_SRC   per source: 00 none, 01 EX/MEM, 10 MEM/WB
//   stall           out  1           hold PC and IF/ID, bubble into ID/EX
//   sb_busy         out  1           any scoreboard counter nonzero
//   perf_stall_cnt, perf_lu_cnt  out 32 each  performance counters (see CONFIGURATION)
// BEHAVIOUR
//   Reg match(a,ba,b,bb): a==b && ba==bb && !(ba==0 && a==0). Int x0 never matches; float f0 does.
//   fwd_sel (combinational): EX/MEM match with regwrite -> 01; else MEM/WB match -> 10; else 00.
//     EX/MEM has priority when both match.
//   load_use = id_valid && id_ex_is_load && id_ex_regwrite && any used ID source matches id_ex_rd.
//   sb_hit = id_valid && (any used ID source, or id_rd if id_rd_wr) maps to entry with cnt!=0.
//     RAW and WAW both covered.
//   stall = load_use || sb_hit (combinational from inputs + registered scoreboard).
//   Scoreboard: 2*2**AW counters of LW bits, reset 0.
//     Accepted issue = id_valid && id_rd_wr && issue_lat!=0 && !stall && not int x0.
//       Sets cnt[id_rd_bank,id_rd] <= issue_lat on next clk.
//     All other nonzero counters decrement by 1 every cycle. Issue to a counter also due to
//       decrement: the load wins.
//     issue_lat > MAX_LAT saturates to MAX_LAT.
//   Last busy cycle: the cycle with cnt==1 still stalls. Dependent instruction leaves ID when
//     cnt==0 and picks up the result through the MEM/WB path.
//   Reset: async, mid-operation; all counters 0; stall=0, sb_busy=0, perf counters 0.
//     fwd_sel follows inputs.
//   No flush input: in-flight multi-cycle ops always complete.
// CONFIGURATION
//   FWD_PERF_CNT_EN defined:
//     perf_stall_cnt increments every cycle with stall=1.
//     perf_lu_cnt increments every cycle with load_use=1.
//     Both wrap at 2**32.
//   Undefined: both ports tied to 32'd0; no flops inferred.
// STRUCTURE
//   Package fwd_pkg:
//     localparams FWD_NONE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10; BANK_INT=1'b0, BANK_FP=1'b1.
//     Function reg_match(addr_a, bank_a, addr_b, bank_b) implementing the x0 rule.
//   Sub-module fwd_sb_counter (one LW-bit counter):
//     inputs load, load_val; output busy.
//     Instantiated 2*2**AW times via generate.
// TESTING
//   1. EX/MEM writes x5, MEM/WB writes x5, EX rs1=x5 int -> fwd_sel[1:0]=01.
//      Disable EX/MEM regwrite -> 10.
//   2. Int rs2=x0 with EX/MEM rd=x0 -> 00. Float rs2=f0 with EX/MEM rd=f0 bank1 -> 01.
//      Bank mismatch (rd x7 int, rs f7 float) -> 00.
//   3. lw x3 in EX, ID add uses x3 -> stall=1 exactly one cycle.
//      Next cycle (load in MEM) EX rs=x3 gets 10.
//   4. fdiv f2 issue_lat=4, dependent fadd reads f2 next cycle -> stall 4 cycles.
//      sb_busy falls with stall.
//   5. WAW: fdiv f4 lat 3 then fmv writing f4 -> stall until cnt 0.
//      Assert rst_n=0 mid-stall -> stall and sb_busy drop immediately.
//   6. With FWD_PERF_CNT_EN, scenario 3+4 -> perf_stall_cnt=5, perf_lu_cnt=1.
//      Without the macro -> both 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
//   Shared constants and helpers for the forwarding / hazard scoreboard.
//
//   Contents:
//     FWD_NONE / FWD_EXMEM / FWD_MEMWB  2-bit forward-select encodings
//     BANK_INT / BANK_FP                register-bank identifiers
//     fwd_addr_t                        widest register address accepted by
//                                       reg_match (callers zero-extend)
//     reg_match()                       register-identity compare with the
//                                       hard-wired int x0 exclusion
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic BANK_INT = 1'b0;
    localparam logic BANK_FP  = 1'b1;

    // Register addresses up to this width are supported by reg_match.
    localparam int FWD_ADDR_MAX = 8;
    typedef logic [FWD_ADDR_MAX-1:0] fwd_addr_t;

    // Two register references name the same architectural register.
    // Integer x0 is hard-wired to zero and therefore never produces a
    // dependency; float f0 is an ordinary register and does.
    function automatic logic reg_match(
        input fwd_addr_t addr_a,
        input logic      bank_a,
        input fwd_addr_t addr_b,
        input logic      bank_b
    );
        return (addr_a == addr_b) && (bank_a == bank_b) &&
               !((bank_a == BANK_INT) && (addr_a == '0));
    endfunction

endpackage : fwd_pkg

// File: rtl/fwd_sb_counter.sv
// -----------------------------------------------------------------------------
// fwd_sb_counter
//   One scoreboard entry: remaining-latency countdown for a single
//   architectural register with an outstanding multi-cycle result.
//
//   Parameters:
//     LW        counter width
//   Ports:
//     clk       in   pipeline clock
//     rst_n     in   async active-low reset, clears the count
//     load      in   accepted multi-cycle issue targeting this register
//     load_val  in   latency to load (already saturated by the caller)
//     busy      out  count is nonzero, result not yet available
//
//   A load takes precedence over the free-running decrement so that a new
//   issue to a register whose previous result is just draining is not lost.
// -----------------------------------------------------------------------------
module fwd_sb_counter #(
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    output logic          busy
);

    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_d;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule : fwd_sb_counter

// File: rtl/fwd_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_hazard_scoreboard
//   Forwarding and hazard unit for the integer + floating-point pipeline.
//   Generates EX-stage operand forward selects, detects load-use hazards in
//   ID, and tracks outstanding multi-cycle results (FP div/sqrt/FMA) in a
//   per-register latency scoreboard. The combined stall holds PC and IF/ID
//   and injects a bubble into ID/EX.
//
//   Optional feature (compile-time macro FWD_PERF_CNT_EN):
//     defined   -> perf_stall_cnt / perf_lu_cnt count stall and load-use
//                  cycles, wrapping at 2**32
//     undefined -> both outputs tied to zero, no counter flops
//
//   Parameters:
//     AW       register address width (2**AW registers per bank)
//     NUM_SRC  source operands per instruction
//     MAX_LAT  longest multi-cycle latency; larger requests saturate
//
//   Ports:
//     clk, rst_n                          clock, async active-low reset
//     id_valid                            valid instruction in ID
//     id_rs_addr/id_rs_bank/id_rs_used    ID sources (bank 1 = float)
//     id_rd/id_rd_bank/id_rd_wr           ID destination
//     issue_lat                           ID latency, 0 = single-cycle op
//     id_ex_rd/_rd_bank/_regwrite/_is_load  instruction currently in EX
//     ex_rs_addr/ex_rs_bank               EX sources to be forwarded
//     ex_mem_rd/_rd_bank/_regwrite        EX/MEM producer
//     mem_wb_rd/_rd_bank/_regwrite        MEM/WB producer
//     fwd_sel                             2 bits per EX source
//                                         (00 none, 01 EX/MEM, 10 MEM/WB)
//     stall                               load-use or scoreboard hazard
//     sb_busy                             any scoreboard entry nonzero
//     perf_stall_cnt/perf_lu_cnt          performance counters
// -----------------------------------------------------------------------------
module fwd_hazard_scoreboard
    import fwd_pkg::*;
#(
    parameter  int AW      = 5,
    parameter  int NUM_SRC = 3,
    parameter  int MAX_LAT = 8,
    localparam int LW      = $clog2(MAX_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   id_valid,
    input  logic [NUM_SRC*AW-1:0]  id_rs_addr,
    input  logic [NUM_SRC-1:0]     id_rs_bank,
    input  logic [NUM_SRC-1:0]     id_rs_used,
    input  logic [AW-1:0]          id_rd,
    input  logic                   id_rd_bank,
    input  logic                   id_rd_wr,
    input  logic [LW-1:0]          issue_lat,

    input  logic [AW-1:0]          id_ex_rd,
    input  logic                   id_ex_rd_bank,
    input  logic                   id_ex_regwrite,
    input  logic                   id_ex_is_load,

    input  logic [NUM_SRC*AW-1:0]  ex_rs_addr,
    input  logic [NUM_SRC-1:0]     ex_rs_bank,

    input  logic [AW-1:0]          ex_mem_rd,
    input  logic                   ex_mem_rd_bank,
    input  logic                   ex_mem_regwrite,

    input  logic [AW-1:0]          mem_wb_rd,
    input  logic                   mem_wb_rd_bank,
    input  logic                   mem_wb_regwrite,

    output logic [2*NUM_SRC-1:0]   fwd_sel,
    output logic                   stall,
    output logic                   sb_busy,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_lu_cnt
);

    // Scoreboard index is {bank, addr}: integer regs first, float regs after.
    localparam int IW   = AW + 1;
    localparam int NCNT = 2 ** IW;

    logic [NCNT-1:0] cnt_busy;
    logic            lu_src_hit;
    logic            sb_src_hit;
    logic            sb_rd_hit;
    logic            load_use;
    logic            sb_hit;
    logic            issue_ok;
    logic [IW-1:0]   issue_idx;
    logic [LW-1:0]   lat_sat;

    // -------------------------------------------------------------------------
    // EX-stage forwarding. The younger producer (EX/MEM) wins when both
    // pipeline registers hold the same destination.
    // -------------------------------------------------------------------------
    always_comb begin
        fwd_sel = {NUM_SRC{FWD_NONE}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_mem_regwrite &&
                reg_match(fwd_addr_t'(ex_rs_addr[i*AW +: AW]), ex_rs_bank[i],
                          fwd_addr_t'(ex_mem_rd), ex_mem_rd_bank)) begin
                fwd_sel[2*i +: 2] = FWD_EXMEM;
            end else if (mem_wb_regwrite &&
                reg_match(fwd_addr_t'(ex_rs_addr[i*AW +: AW]), ex_rs_bank[i],
                          fwd_addr_t'(mem_wb_rd), mem_wb_rd_bank)) begin
                fwd_sel[2*i +: 2] = FWD_MEMWB;
            end
        end
    end

    // -------------------------------------------------------------------------
    // ID-stage hazard detection
    // -------------------------------------------------------------------------
    always_comb begin
        lu_src_hit = 1'b0;
        sb_src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i]) begin
                if (reg_match(fwd_addr_t'(id_rs_addr[i*AW +: AW]), id_rs_bank[i],
                              fwd_addr_t'(id_ex_rd), id_ex_rd_bank)) begin
                    lu_src_hit = 1'b1;
                end
                // RAW against an outstanding multi-cycle result.
                if (cnt_busy[{id_rs_bank[i], id_rs_addr[i*AW +: AW]}]) begin
                    sb_src_hit = 1'b1;
                end
            end
        end
    end

    // WAW: a later write must not retire ahead of the pending long-latency one.
    assign sb_rd_hit = id_rd_wr && cnt_busy[{id_rd_bank, id_rd}];

    assign load_use = id_valid && id_ex_is_load && id_ex_regwrite && lu_src_hit;
    assign sb_hit   = id_valid && (sb_src_hit || sb_rd_hit);
    assign stall    = load_use || sb_hit;
    assign sb_busy  = |cnt_busy;

    // -------------------------------------------------------------------------
    // Scoreboard issue. A stalled instruction is not accepted, and int x0 has
    // no storage so writing it never needs tracking.
    // -------------------------------------------------------------------------
    assign issue_idx = {id_rd_bank, id_rd};
    assign issue_ok  = id_valid && id_rd_wr && (issue_lat != '0) && !stall &&
                       !((id_rd_bank == BANK_INT) && (id_rd == '0));
    assign lat_sat   = (issue_lat > LW'(MAX_LAT)) ? LW'(MAX_LAT) : issue_lat;

    // NOTE: the scoreboard is an array of individual flops, not RAM, so every
    // entry is cleared by reset; a stale count after reset would deadlock ID.
    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        fwd_sb_counter #(
            .LW (LW)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (issue_ok && (issue_idx == IW'(g))),
            .load_val (lat_sat),
            .busy     (cnt_busy[g])
        );
    end

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_lu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_lu_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_q + {31'd0, stall};
            perf_lu_q    <= perf_lu_q + {31'd0, load_use};
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_lu_cnt    = perf_lu_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_lu_cnt    = 32'd0;
`endif

endmodule : fwd_hazard_scoreboard

// File: tb/tb_fwd_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_scoreboard
//   Directed scenarios followed by randomized traffic, all compared against a
//   behavioural model that tracks each register's "ready cycle" rather than a
//   countdown. Works with and without FWD_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_scoreboard;
    import fwd_pkg::*;

    localparam int AW = 5;
    localparam int NS = 3;
    localparam int MAXL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [14:0] id_rs_addr;
    logic [2:0]  id_rs_bank, id_rs_used;
    logic [4:0]  id_rd;
    logic        id_rd_bank, id_rd_wr;
    logic [3:0]  issue_lat;
    logic [4:0]  id_ex_rd;
    logic        id_ex_rd_bank, id_ex_regwrite, id_ex_is_load;
    logic [14:0] ex_rs_addr;
    logic [2:0]  ex_rs_bank;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_rd_bank, ex_mem_regwrite;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_rd_bank, mem_wb_regwrite;
    logic [5:0]  fwd_sel;
    logic        stall, sb_busy;
    logic [31:0] perf_stall_cnt, perf_lu_cnt;

    fwd_hazard_scoreboard #(.AW(AW), .NUM_SRC(NS), .MAX_LAT(MAXL)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs_addr      (id_rs_addr),
        .id_rs_bank      (id_rs_bank),
        .id_rs_used      (id_rs_used),
        .id_rd           (id_rd),
        .id_rd_bank      (id_rd_bank),
        .id_rd_wr        (id_rd_wr),
        .issue_lat       (issue_lat),
        .id_ex_rd        (id_ex_rd),
        .id_ex_rd_bank   (id_ex_rd_bank),
        .id_ex_regwrite  (id_ex_regwrite),
        .id_ex_is_load   (id_ex_is_load),
        .ex_rs_addr      (ex_rs_addr),
        .ex_rs_bank      (ex_rs_bank),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_rd_bank  (ex_mem_rd_bank),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_rd_bank  (mem_wb_rd_bank),
        .mem_wb_regwrite (mem_wb_regwrite),
        .fwd_sel         (fwd_sel),
        .stall           (stall),
        .sb_busy         (sb_busy),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_lu_cnt     (perf_lu_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: cycle at which each register's pending result is
    // available. A register is busy while the current cycle is earlier.
    int ready_cyc [2][32];
    int cyc = 0;
    int m_stall_cnt = 0;
    int m_lu_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] perf_exp(input int v);
`ifdef FWD_PERF_CNT_EN
        return 32'(v);
`else
        return 32'd0 & 32'(v);
`endif
    endfunction

    function automatic bit same_reg(input int a, input bit ba, input int b, input bit bb);
        return (a == b) && (ba == bb) && !(ba == 1'b0 && a == 0);
    endfunction

    function automatic bit reg_busy(input bit bk, input int r);
        return cyc < ready_cyc[bk][r];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 32; r++) ready_cyc[b][r] = 0;
        m_stall_cnt = 0;
        m_lu_cnt    = 0;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs_addr = '0; id_rs_bank = '0; id_rs_used = '0;
        id_rd = '0; id_rd_bank = 0; id_rd_wr = 0; issue_lat = '0;
        id_ex_rd = '0; id_ex_rd_bank = 0; id_ex_regwrite = 0; id_ex_is_load = 0;
        ex_rs_addr = '0; ex_rs_bank = '0;
        ex_mem_rd = '0; ex_mem_rd_bank = 0; ex_mem_regwrite = 0;
        mem_wb_rd = '0; mem_wb_rd_bank = 0; mem_wb_regwrite = 0;
    endtask

    task automatic set_id_src(input int i, input int a, input bit bk, input bit used);
        id_rs_addr[i*5 +: 5] = 5'(a);
        id_rs_bank[i] = bk;
        id_rs_used[i] = used;
    endtask

    task automatic set_ex_src(input int i, input int a, input bit bk);
        ex_rs_addr[i*5 +: 5] = 5'(a);
        ex_rs_bank[i] = bk;
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    // Compares all outputs against the model, then advances the model.
    task automatic tick(input string tag);
        logic [5:0] e_fwd;
        bit e_lu, e_sb, e_stall, e_busy;
        int lat;
        #1;
        e_fwd = '0;
        for (int i = 0; i < NS; i++) begin
            if (ex_mem_regwrite && same_reg(int'(ex_rs_addr[i*5 +: 5]), ex_rs_bank[i],
                                            int'(ex_mem_rd), ex_mem_rd_bank))
                e_fwd[2*i +: 2] = 2'b01;
            else if (mem_wb_regwrite && same_reg(int'(ex_rs_addr[i*5 +: 5]), ex_rs_bank[i],
                                                 int'(mem_wb_rd), mem_wb_rd_bank))
                e_fwd[2*i +: 2] = 2'b10;
        end
        e_lu = 0;
        e_sb = 0;
        for (int i = 0; i < NS; i++) begin
            if (id_rs_used[i]) begin
                if (same_reg(int'(id_rs_addr[i*5 +: 5]), id_rs_bank[i], int'(id_ex_rd), id_ex_rd_bank))
                    e_lu = 1;
                if (reg_busy(id_rs_bank[i], int'(id_rs_addr[i*5 +: 5])))
                    e_sb = 1;
            end
        end
        if (id_rd_wr && reg_busy(id_rd_bank, int'(id_rd))) e_sb = 1;
        e_lu    = id_valid && id_ex_is_load && id_ex_regwrite && e_lu;
        e_sb    = id_valid && e_sb;
        e_stall = e_lu || e_sb;
        e_busy  = 0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 32; r++)
                if (reg_busy(b[0], r)) e_busy = 1;

        check({tag, ".fwd_sel"}, 32'(fwd_sel), 32'(e_fwd));
        check({tag, ".stall"}, 32'(stall), 32'(e_stall));
        check({tag, ".sb_busy"}, 32'(sb_busy), 32'(e_busy));
        check({tag, ".perf_stall"}, perf_stall_cnt, perf_exp(m_stall_cnt));
        check({tag, ".perf_lu"}, perf_lu_cnt, perf_exp(m_lu_cnt));

        // Model update for the coming rising edge.
        if (id_valid && id_rd_wr && issue_lat != 0 && !e_stall &&
            !(id_rd_bank == 1'b0 && id_rd == 0)) begin
            lat = (int'(issue_lat) > MAXL) ? MAXL : int'(issue_lat);
            ready_cyc[id_rd_bank][id_rd] = cyc + 1 + lat;
        end
        m_stall_cnt += int'(e_stall);
        m_lu_cnt    += int'(e_lu);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        #1;
        check("reset.stall", 32'(stall), 32'd0);
        check("reset.sb_busy", 32'(sb_busy), 32'd0);
        check("reset.perf_stall", perf_stall_cnt, 32'd0);
        check("reset.perf_lu", perf_lu_cnt, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 1;
        clear_inputs();
        #1;
        do_reset();

        // 1: EX/MEM priority over MEM/WB, then MEM/WB alone
        ex_mem_rd = 5; ex_mem_regwrite = 1;
        mem_wb_rd = 5; mem_wb_regwrite = 1;
        set_ex_src(0, 5, BANK_INT);
        #1 check("t1.exmem", 32'(fwd_sel[1:0]), 32'(2'b01));
        tick("t1a");
        ex_mem_regwrite = 0;
        #1 check("t1.memwb", 32'(fwd_sel[1:0]), 32'(2'b10));
        tick("t1b");

        // 2: x0 never forwards, f0 does, bank mismatch does not
        clear_inputs();
        ex_mem_rd = 0; ex_mem_rd_bank = BANK_INT; ex_mem_regwrite = 1;
        set_ex_src(1, 0, BANK_INT);
        #1 check("t2.x0", 32'(fwd_sel[3:2]), 32'(2'b00));
        tick("t2a");
        ex_mem_rd_bank = BANK_FP;
        set_ex_src(1, 0, BANK_FP);
        #1 check("t2.f0", 32'(fwd_sel[3:2]), 32'(2'b01));
        tick("t2b");
        ex_mem_rd = 7; ex_mem_rd_bank = BANK_INT;
        set_ex_src(1, 7, BANK_FP);
        #1 check("t2.bank", 32'(fwd_sel[3:2]), 32'(2'b00));
        tick("t2c");

        // 3: load-use -> one stall cycle, then MEM/WB forward
        clear_inputs();
        id_valid = 1; set_id_src(0, 3, BANK_INT, 1);
        id_rd = 10; id_rd_wr = 1;
        id_ex_rd = 3; id_ex_regwrite = 1; id_ex_is_load = 1;
        #1 check("t3.stall", 32'(stall), 32'd1);
        tick("t3a");
        id_ex_regwrite = 0; id_ex_is_load = 0;
        ex_mem_rd = 3; ex_mem_regwrite = 1;
        #1 check("t3.release", 32'(stall), 32'd0);
        tick("t3b");
        clear_inputs();
        set_ex_src(0, 3, BANK_INT);
        mem_wb_rd = 3; mem_wb_regwrite = 1;
        #1 check("t3.fwd", 32'(fwd_sel[1:0]), 32'(2'b10));
        tick("t3c");

        // 4: fdiv f2 lat 4, dependent fadd stalls 4 cycles
        clear_inputs();
        id_valid = 1; id_rd = 2; id_rd_bank = BANK_FP; id_rd_wr = 1; issue_lat = 4;
        tick("t4.issue");
        issue_lat = 0; id_rd = 6;
        set_id_src(0, 2, BANK_FP, 1);
        set_id_src(1, 3, BANK_FP, 1);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4.stall", 32'(stall), 32'd1);
            check("t4.busy", 32'(sb_busy), 32'd1);
            tick("t4.wait");
        end
        #1;
        check("t4.free", 32'(stall), 32'd0);
        check("t4.idle", 32'(sb_busy), 32'd0);
        tick("t4.go");

        // 6: perf counters after scenarios 3 and 4
        clear_inputs();
        #1;
        check("t6.perf_stall", perf_stall_cnt, perf_exp(5));
        check("t6.perf_lu", perf_lu_cnt, perf_exp(1));
        tick("t6");

        // 5: WAW on f4, then reset in the middle of the stall
        id_valid = 1; id_rd = 4; id_rd_bank = BANK_FP; id_rd_wr = 1; issue_lat = 3;
        tick("t5.issue");
        issue_lat = 0;
        set_id_src(0, 9, BANK_INT, 1);
        #1 check("t5.waw", 32'(stall), 32'd1);
        tick("t5.w1");
        #1 check("t5.waw2", 32'(stall), 32'd1);
        #1 rst_n = 0;
        #1;
        check("t5.rst_stall", 32'(stall), 32'd0);
        check("t5.rst_busy", 32'(sb_busy), 32'd0);
        @(negedge clk);
        do_reset();

        // Saturation: lat 15 acts as MAX_LAT
        id_valid = 1; id_rd = 1; id_rd_bank = BANK_FP; id_rd_wr = 1; issue_lat = 15;
        tick("sat.issue");
        issue_lat = 0; id_rd = 8;
        set_id_src(2, 1, BANK_FP, 1);
        for (int k = 0; k < MAXL; k++) begin
            #1 check("sat.stall", 32'(stall), 32'd1);
            tick("sat.wait");
        end
        #1 check("sat.free", 32'(stall), 32'd0);
        tick("sat.go");

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            id_valid = ($urandom % 4) != 0;
            for (int i = 0; i < NS; i++) begin
                set_id_src(i, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                set_ex_src(i, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
            id_rd = 5'($urandom_range(0, 3)); id_rd_bank = 1'($urandom_range(0, 1));
            id_rd_wr = 1'($urandom_range(0, 1));
            issue_lat = (($urandom % 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            id_ex_rd = 5'($urandom_range(0, 3)); id_ex_rd_bank = 1'($urandom_range(0, 1));
            id_ex_regwrite = 1'($urandom_range(0, 1)); id_ex_is_load = 1'($urandom_range(0, 1));
            ex_mem_rd = 5'($urandom_range(0, 3)); ex_mem_rd_bank = 1'($urandom_range(0, 1));
            ex_mem_regwrite = 1'($urandom_range(0, 1));
            mem_wb_rd = 5'($urandom_range(0, 3)); mem_wb_rd_bank = 1'($urandom_range(0, 1));
            mem_wb_regwrite = 1'($urandom_range(0, 1));
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_fwd_hazard_scoreboard
